counter_cfg_sequencer: RTL and testbench

//  Bus-master stage directly upstream of the up/down counter. Accepts one configuration
//  (PLR/ULR/LLR/CCR) over a valid/ready handshake and range-checks it. Writes the four

---
 rtl/counter_cfg_sequencer.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_counter_cfg_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : counter_cfg_sequencer
// Description : Bus master placed in front of the up/down counter. Accepts one
//               configuration (PLR/ULR/LLR/CCR) over a valid/ready handshake,
//               range-checks it and writes the four registers through the
//               counter's ncs/nwr/A0/A1/Din bus. It then pulses start, waits
//               for ec/err and reports a single completion status.
//               Optional feature macro: READBACK_VERIFY_EN (reads all four
//               registers back after the writes and compares them).
// Ports       : clk_in, reset_in           clock, synchronous active-high reset
//               cfg_valid_in/cfg_ready_out config handshake (ready only in IDLE)
//               plr_in/ulr_in/llr_in/ccr_in configuration values
//               dout_out/din_in            bus write / read data
//               ncs_out/nwr_out/nrd_out    active-low bus strobes
//               a0_out/a1_out              register select {a0,a1}
//               start_out                  one-cycle start pulse to counter
//               ec_in/err_in               counter end-of-count / error flags
//               busy_out/done_out/status_out  progress and completion status
// Revision    : 1.0  initial release
// ============================================================================
module counter_cfg_sequencer #(
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              cfg_valid_in,
    output logic              cfg_ready_out,
    input  logic [DATA_W-1:0] plr_in,
    input  logic [DATA_W-1:0] ulr_in,
    input  logic [DATA_W-1:0] llr_in,
    input  logic [DATA_W-1:0] ccr_in,
    output logic [DATA_W-1:0] dout_out,
    input  logic [DATA_W-1:0] din_in,
    output logic              ncs_out,
    output logic              nwr_out,
    output logic              nrd_out,
    output logic              a0_out,
    output logic              a1_out,
    output logic              start_out,
    input  logic              ec_in,
    input  logic              err_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [1:0]        status_out
);

    // Phase counter only has to reach the longest of the three bus phases.
    localparam int PH_MAX = (SETUP_CYC > STROBE_CYC)
                          ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                          : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CNT_W  = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_CFG_ERR = 2'b01;
    localparam logic [1:0] ST_RUN_ERR = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CHECK  = 4'd1,
        S_SETUP  = 4'd2,
        S_STROBE = 4'd3,
        S_HOLD   = 4'd4,
        S_GAP    = 4'd5,
        S_START  = 4'd6,
        S_WAIT   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [TMR_W-1:0]  timer_q,  timer_d;
    logic [1:0]        idx_q,    idx_d;     // register being accessed, 0=PLR..3=CCR
    logic [1:0]        addr_q,   addr_d;
    logic [DATA_W-1:0] dout_q,   dout_d;
    logic [1:0]        status_q, status_d;
    logic [DATA_W-1:0] plr_q, plr_d, ulr_q, ulr_d, llr_q, llr_d, ccr_q, ccr_d;
`ifdef READBACK_VERIFY_EN
    logic              rd_q,     rd_d;      // 0 = write pass, 1 = read-back pass
    logic              mism_q,   mism_d;
`else
    logic              w_unused_din;
    assign w_unused_din = ^din_in;
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            timer_q  <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            status_q <= ST_OK;
            plr_q    <= '0;
            ulr_q    <= '0;
            llr_q    <= '0;
            ccr_q    <= '0;
`ifdef READBACK_VERIFY_EN
            rd_q     <= 1'b0;
            mism_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            status_q <= status_d;
            plr_q    <= plr_d;
            ulr_q    <= ulr_d;
            llr_q    <= llr_d;
            ccr_q    <= ccr_d;
`ifdef READBACK_VERIFY_EN
            rd_q     <= rd_d;
            mism_q   <= mism_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        status_d = status_q;
        plr_d    = plr_q;
        ulr_d    = ulr_q;
        llr_d    = llr_q;
        ccr_d    = ccr_q;
`ifdef READBACK_VERIFY_EN
        rd_d     = rd_q;
        mism_d   = mism_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cfg_valid_in) begin
                    plr_d   = plr_in;
                    ulr_d   = ulr_in;
                    llr_d   = llr_in;
                    ccr_d   = ccr_in;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((llr_q > plr_q) || (plr_q > ulr_q) || (ccr_q == '0)) begin
                    status_d = ST_CFG_ERR;
                    state_d  = S_DONE;
                end else begin
                    cnt_d   = '0;
                    idx_d   = 2'd0;
`ifdef READBACK_VERIFY_EN
                    rd_d    = 1'b0;
                    mism_d  = 1'b0;
`endif
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
`ifdef READBACK_VERIFY_EN
                    // dout still carries the value written to this register,
                    // so it doubles as the expected read-back value.
                    if (rd_q && (din_in != dout_q)) begin
                        mism_d = 1'b1;
                    end
`endif
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                cnt_d = '0;
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_SETUP;
                end
`ifdef READBACK_VERIFY_EN
                else if (!rd_q) begin
                    rd_d    = 1'b1;
                    idx_d   = 2'd0;
                    state_d = S_SETUP;
                end else if (mism_q) begin
                    status_d = ST_CFG_ERR;
                    state_d  = S_DONE;
                end
`endif
                else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // err has priority over ec when both arrive together.
                if (err_in) begin
                    status_d = ST_RUN_ERR;
                    state_d  = S_DONE;
                end else if (ec_in) begin
                    status_d = ST_OK;
                    state_d  = S_DONE;
                end else if (timer_q == TMR_LAST) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Address and data move only on entry to SETUP, so they are stable
        // for the whole SETUP/STROBE/HOLD window of every access.
        if ((state_d == S_SETUP) && (state_q != S_SETUP)) begin
            addr_d = idx_d;
            case (idx_d)
                2'd0:    dout_d = plr_q;
                2'd1:    dout_d = ulr_q;
                2'd2:    dout_d = llr_q;
                default: dout_d = ccr_q;
            endcase
        end
    end

    // Bus and status outputs are decoded from registered state only.
    always_comb begin
        cfg_ready_out = (state_q == S_IDLE);
        busy_out      = (state_q != S_IDLE);
        ncs_out       = !((state_q == S_SETUP) || (state_q == S_STROBE) ||
                          (state_q == S_HOLD));
`ifdef READBACK_VERIFY_EN
        nwr_out       = !((state_q == S_STROBE) && !rd_q);
        nrd_out       = !((state_q == S_STROBE) &&  rd_q);
`else
        nwr_out       = !(state_q == S_STROBE);
        nrd_out       = 1'b1;
`endif
        start_out     = (state_q == S_START);
        done_out      = (state_q == S_DONE);
        status_out    = status_q;
        dout_out      = dout_q;
        a0_out        = addr_q[1];
        a1_out        = addr_q[0];
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_cfg_sequencer
// Description : Directed self-checking bench for counter_cfg_sequencer. A bus
//               monitor records every write strobe, strobe lengths and pulse
//               counts; each scenario task checks those records against
//               hand-computed values. Define READBACK_VERIFY_EN to also run the
//               read-back scenario.
// Revision    : 1.0  initial release
// ============================================================================
module tb_counter_cfg_sequencer;

    localparam int TIMEOUT = 1024;
`ifdef READBACK_VERIFY_EN
    localparam int START_OFS = 41;   // CHECK + 20 write cycles + 20 read cycles
    localparam int NCS_EXP   = 32;
    localparam int NRD_EXP   = 8;
`else
    localparam int START_OFS = 21;   // CHECK + 20 write cycles
    localparam int NCS_EXP   = 16;
    localparam int NRD_EXP   = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_in, cfg_valid_in, cfg_ready_out;
    logic [7:0] plr_in, ulr_in, llr_in, ccr_in, dout_out, din_in;
    logic       ncs_out, nwr_out, nrd_out, a0_out, a1_out, start_out;
    logic       ec_in, err_in, busy_out, done_out;
    logic [1:0] status_out;

    logic [31:0] rb_bank;
    logic        rb_corrupt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    counter_cfg_sequencer #(
        .DATA_W(8), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in(clk), .reset_in(reset_in),
        .cfg_valid_in(cfg_valid_in), .cfg_ready_out(cfg_ready_out),
        .plr_in(plr_in), .ulr_in(ulr_in), .llr_in(llr_in), .ccr_in(ccr_in),
        .dout_out(dout_out), .din_in(din_in),
        .ncs_out(ncs_out), .nwr_out(nwr_out), .nrd_out(nrd_out),
        .a0_out(a0_out), .a1_out(a1_out), .start_out(start_out),
        .ec_in(ec_in), .err_in(err_in),
        .busy_out(busy_out), .done_out(done_out), .status_out(status_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model for read-back; optionally corrupts the ULR read.
    always_comb begin
        din_in = rb_bank[{a0_out, a1_out}*8 +: 8];
        if (rb_corrupt && ({a0_out, a1_out} == 2'b01)) din_in = 8'd21;
    end

    // ---------------- bus monitor (records, never judges) ----------------
    logic [1:0] wr_a[$];
    logic [7:0] wr_d[$];
    int         wr_len[$];
    logic       prev_nwr = 1'b1;
    logic [1:0] cur_a;
    logic [7:0] cur_d;
    int cur_len = 0, unstable_cnt = 0, ncs_low = 0, nwr_low = 0, nrd_low = 0;
    int start_cnt = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0;
    logic [1:0] done_status;

    always @(negedge clk) begin
        if (!nwr_out) begin
            if (prev_nwr) begin
                cur_len = 1; cur_a = {a0_out, a1_out}; cur_d = dout_out;
            end else begin
                cur_len++;
                if (({a0_out, a1_out} != cur_a) || (dout_out != cur_d)) unstable_cnt++;
            end
            if (ncs_out) unstable_cnt++;
        end else if (!prev_nwr) begin
            wr_a.push_back(cur_a); wr_d.push_back(cur_d); wr_len.push_back(cur_len);
        end
        prev_nwr = nwr_out;
        if (!ncs_out) ncs_low++;
        if (!nwr_out) nwr_low++;
        if (!nrd_out) nrd_low++;
        if (start_out) begin start_cnt++; start_cyc = cyc; end
        if (done_out) begin done_cnt++; done_cyc = cyc; done_status = status_out; end
    end

    task automatic clear_mon();
        wr_a.delete(); wr_d.delete(); wr_len.delete();
        unstable_cnt = 0; ncs_low = 0; nwr_low = 0; nrd_low = 0;
        start_cnt = 0; done_cnt = 0;
    endtask

    // Presents one config for a single cycle; n = count value after edge N.
    task automatic send_cfg(input logic [7:0] p, u, l, c, output int n);
        @(negedge clk);
        plr_in = p; ulr_in = u; llr_in = l; ccr_in = c; cfg_valid_in = 1'b1;
        n = cyc + 1;
        @(negedge clk);
        cfg_valid_in = 1'b0;
    endtask

    task automatic wait_start(input int limit, output bit expired);
        int n = 0;
        while (start_cnt == 0 && n < limit) begin @(negedge clk); n++; end
        expired = (start_cnt == 0);
    endtask

    task automatic wait_done(input int limit, output bit expired);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin @(negedge clk); n++; end
        expired = (done_cnt == 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cfg_ready_out, ncs_out, nwr_out, nrd_out} !== 4'b1111) begin
            errors++; $display("FAIL reset_strobes: got %b expected 1111",
                               {cfg_ready_out, ncs_out, nwr_out, nrd_out});
        end
        checks++;
        if ({a0_out, a1_out, start_out, busy_out, done_out} !== 5'b00000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000",
                               {a0_out, a1_out, start_out, busy_out, done_out});
        end
        checks++;
        if (dout_out !== 8'd0 || status_out !== 2'b00) begin
            errors++; $display("FAIL reset_data: dout=%0d status=%b expected 0/00", dout_out, status_out);
        end
        reset_in = 1'b0;
        @(negedge clk);
        checks++;
        if (cfg_ready_out !== 1'b1 || busy_out !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: ready=%b busy=%b expected 1/0", cfg_ready_out, busy_out);
        end
        clear_mon();
    endtask

    task automatic test_write_sequence();
        logic [1:0] ea[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [7:0] ed[4] = '{8'd10, 8'd20, 8'd5, 8'd2};
        int n; bit exp;
        clear_mon();
        rb_bank = {8'd2, 8'd5, 8'd20, 8'd10}; rb_corrupt = 1'b0;
        send_cfg(8'd10, 8'd20, 8'd5, 8'd2, n);
        checks++;
        if (cfg_ready_out !== 1'b0 || busy_out !== 1'b1) begin
            errors++; $display("FAIL t1_busy: ready=%b busy=%b expected 0/1", cfg_ready_out, busy_out);
        end
        wait_start(100, exp);
        checks++;
        if (exp || start_cyc != n + START_OFS) begin
            errors++; $display("FAIL t1_start_cyc: got %0d expected %0d", start_cyc - n, START_OFS);
        end
        while (cyc < start_cyc + 50) @(negedge clk);
        ec_in = 1'b1;
        @(negedge clk);
        ec_in = 1'b0;
        wait_done(20, exp);
        checks++;
        if (exp || done_cyc != start_cyc + 51 || done_status !== 2'b00) begin
            errors++; $display("FAIL t1_done: latency=%0d status=%b expected 51/00",
                               done_cyc - start_cyc, done_status);
        end
        checks++;
        if (wr_a.size() != 4) begin
            errors++; $display("FAIL t1_write_count: got %0d expected 4", wr_a.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < wr_a.size()) begin
                checks++;
                if (wr_a[i] !== ea[i] || wr_d[i] !== ed[i] || wr_len[i] != 2) begin
                    errors++; $display("FAIL t1_write%0d: got %b:%0d len %0d expected %b:%0d len 2",
                                       i, wr_a[i], wr_d[i], wr_len[i], ea[i], ed[i]);
                end
            end
        end
        checks++;
        if (unstable_cnt != 0 || ncs_low != NCS_EXP || nrd_low != NRD_EXP) begin
            errors++; $display("FAIL t1_bus: unstable=%0d ncs_low=%0d nrd_low=%0d expected 0/%0d/%0d",
                               unstable_cnt, ncs_low, nrd_low, NCS_EXP, NRD_EXP);
        end
        @(negedge clk);
        checks++;
        if (start_cnt != 1 || done_cnt != 1 || cfg_ready_out !== 1'b1 || busy_out !== 1'b0) begin
            errors++; $display("FAIL t1_end: starts=%0d dones=%0d ready=%b busy=%b expected 1/1/1/0",
                               start_cnt, done_cnt, cfg_ready_out, busy_out);
        end
    endtask

    task automatic test_err_priority();
        int n; bit exp;
        clear_mon();
        rb_bank = {8'd4, 8'd1, 8'd9, 8'd3};
        send_cfg(8'd3, 8'd9, 8'd1, 8'd4, n);
        // A second request while busy must be ignored (it would fail CHECK).
        plr_in = 8'd99; cfg_valid_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (cfg_ready_out !== 1'b0) begin
            errors++; $display("FAIL t3_ready_busy: got %b expected 0", cfg_ready_out);
        end
        cfg_valid_in = 1'b0;
        wait_start(100, exp);
        checks++;
        if (exp || wr_d.size() == 0 || wr_d[0] !== 8'd3) begin
            errors++; $display("FAIL t3_ignored_req: start_missing=%0b first write=%0d expected 3",
                               exp, (wr_d.size() > 0) ? wr_d[0] : 8'd0);
        end
        while (cyc < start_cyc + 5) @(negedge clk);
        ec_in = 1'b1; err_in = 1'b1;
        @(negedge clk);
        ec_in = 1'b0; err_in = 1'b0;
        wait_done(20, exp);
        checks++;
        if (exp || done_cyc != start_cyc + 6 || done_status !== 2'b10) begin
            errors++; $display("FAIL t3_status: latency=%0d status=%b expected 6/10",
                               done_cyc - start_cyc, done_status);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != 1 || status_out !== 2'b10) begin
            errors++; $display("FAIL t3_single_done: dones=%0d status=%b expected 1/10", done_cnt, status_out);
        end
    endtask

    task automatic test_cfg_error();
        logic [31:0] vec[3] = '{{8'd30, 8'd20, 8'd5, 8'd1},   // plr > ulr
                                {8'd5,  8'd9,  8'd6, 8'd3},   // llr > plr
                                {8'd5,  8'd9,  8'd1, 8'd0}};  // ccr == 0
        int n; bit exp;
        for (int i = 0; i < 3; i++) begin
            clear_mon();
            send_cfg(vec[i][31:24], vec[i][23:16], vec[i][15:8], vec[i][7:0], n);
            if (i == 0) begin
                checks++;
                if (status_out !== 2'b10) begin
                    errors++; $display("FAIL t2_status_held: got %b expected 10", status_out);
                end
            end
            wait_done(10, exp);
            // done visible after edge N+1, i.e. sampled by edge N+2
            checks++;
            if (exp || done_cyc != n + 1 || done_status !== 2'b01) begin
                errors++; $display("FAIL t2_cfg_err%0d: done at N+%0d status=%b expected N+1/01",
                                   i, done_cyc - n, done_status);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (ncs_low != 0 || nwr_low != 0 || start_cnt != 0) begin
                errors++; $display("FAIL t2_bus_quiet%0d: ncs_low=%0d nwr_low=%0d starts=%0d expected 0/0/0",
                                   i, ncs_low, nwr_low, start_cnt);
            end
        end
    endtask

    task automatic test_timeout();
        int n; bit exp;
        clear_mon();
        rb_bank = {8'd1, 8'd7, 8'd7, 8'd7};
        send_cfg(8'd7, 8'd7, 8'd7, 8'd1, n);   // all limits equal: accepted
        wait_start(100, exp);
        checks++;
        if (exp) begin
            errors++; $display("FAIL t4_start: got no start expected one");
        end
        wait_done(TIMEOUT + 50, exp);
        checks++;
        if (exp || done_cyc != start_cyc + 1 + TIMEOUT || done_status !== 2'b11) begin
            errors++; $display("FAIL t4_timeout: done %0d cycles after WAIT entry status=%b expected %0d/11",
                               done_cyc - start_cyc - 1, done_status, TIMEOUT);
        end
    endtask

    task automatic test_reset_midop();
        int n;
        clear_mon();
        send_cfg(8'd10, 8'd20, 8'd5, 8'd2, n);
        while (cyc < n + 8) @(negedge clk);
        checks++;
        if (nwr_out !== 1'b0 || {a0_out, a1_out} !== 2'b01) begin
            errors++; $display("FAIL t5_in_ulr_strobe: nwr=%b addr=%b expected 0/01", nwr_out, {a0_out, a1_out});
        end
        reset_in = 1'b1;
        @(negedge clk);
        checks++;
        if ({ncs_out, nwr_out, busy_out, cfg_ready_out} !== 4'b1101) begin
            errors++; $display("FAIL t5_released: ncs/nwr/busy/ready=%b expected 1101",
                               {ncs_out, nwr_out, busy_out, cfg_ready_out});
        end
        reset_in = 1'b0;
        repeat (80) @(negedge clk);
        checks++;
        if (start_cnt != 0 || done_cnt != 0 || status_out !== 2'b00) begin
            errors++; $display("FAIL t5_discarded: starts=%0d dones=%0d status=%b expected 0/0/00",
                               start_cnt, done_cnt, status_out);
        end
    endtask

`ifdef READBACK_VERIFY_EN
    task automatic test_readback();
        int n; bit exp;
        clear_mon();
        rb_bank = {8'd2, 8'd5, 8'd20, 8'd10}; rb_corrupt = 1'b1;
        send_cfg(8'd10, 8'd20, 8'd5, 8'd2, n);
        wait_done(100, exp);
        repeat (3) @(negedge clk);
        checks++;
        if (exp || done_status !== 2'b01 || start_cnt != 0 || nrd_low != 8) begin
            errors++; $display("FAIL t6_bad_read: status=%b starts=%0d nrd_low=%0d expected 01/0/8",
                               done_status, start_cnt, nrd_low);
        end
        clear_mon();
        rb_corrupt = 1'b0;
        send_cfg(8'd10, 8'd20, 8'd5, 8'd2, n);
        wait_start(100, exp);
        while (cyc < start_cyc + 3) @(negedge clk);
        ec_in = 1'b1;
        @(negedge clk);
        ec_in = 1'b0;
        wait_done(20, exp);
        checks++;
        if (exp || done_status !== 2'b00 || start_cnt != 1) begin
            errors++; $display("FAIL t6_good_read: status=%b starts=%0d expected 00/1", done_status, start_cnt);
        end
    endtask
`endif

    initial begin
        reset_in = 1'b1; cfg_valid_in = 1'b0;
        plr_in = '0; ulr_in = '0; llr_in = '0; ccr_in = '0;
        ec_in = 1'b0; err_in = 1'b0; rb_bank = '0; rb_corrupt = 1'b0;
        test_reset();
        test_write_sequence();
        test_err_priority();
        test_cfg_error();
        test_timeout();
        test_reset_midop();
`ifdef READBACK_VERIFY_EN
        test_readback();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
